// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end for a single-cycle datapath.
//
// Owns the word-addressed fetch PC, issues one request at a time to a
// variable-latency instruction memory, buffers returned instructions
// (tagged with their PC) in a DEPTH-entry FIFO and hands them to the
// datapath over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the redirect target.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   imem_req/addr      registered fetch request and word address
//   imem_ack/rdata     memory response (ack meaningful only while req=1)
//   redirect_valid/pc  flush and restart fetch at redirect_pc
//   inst_valid/ready   head-of-queue handshake with the datapath
//   inst, inst_pc      head instruction and its PC (NOP / 0 when empty)
//   count              queue occupancy
module ifetch_queue #(
  parameter int              PC_W     = 8,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic                       imem_ack,
  input  logic [INS_W-1:0]           imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INS_W-1:0]           inst,
  output logic [PC_W-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] addr_reg, addr_next;
  logic [PC_W-1:0] redir_reg, redir_next;
  logic [CW-1:0]   count_reg, count_next, count_step;
  logic [AW-1:0]   head_reg, tail_reg;
  logic            push, pop, flush;

  // Small queue kept in registers so the head is visible combinationally
  // in the cycle right after the ack.
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [INS_W-1:0] ins_mem [DEPTH];

  assign imem_req   = (state_reg != IDLE);
  assign imem_addr  = addr_reg;
  assign count      = count_reg;
  assign inst_valid = (count_reg != '0);
  assign inst       = inst_valid ? ins_mem[head_reg] : NOP;
  assign inst_pc    = inst_valid ? pc_mem[head_reg]  : '0;

  // A redirect wins over both push and pop and empties the queue.
  assign flush      = redirect_valid;
  assign push       = imem_req & imem_ack & (state_reg == FETCH) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready & ~redirect_valid;
  assign count_step = count_reg + CW'(push) - CW'(pop);
  assign count_next = flush ? '0 : count_step;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    redir_next = redir_reg;
    case (state_reg)
      IDLE: begin
        if (redirect_valid) begin
          addr_next  = redirect_pc;
          state_next = FETCH;
        end else if (count_step < CW'(DEPTH)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            addr_next = redirect_pc;
          end else begin
            addr_next = addr_reg + 1'b1;
            // Only keep requesting while a free slot is guaranteed.
            if (!(count_step < CW'(DEPTH))) state_next = IDLE;
          end
        end else if (redirect_valid) begin
          // Address must stay put until the in-flight request returns.
          redir_next = redirect_pc;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_valid) redir_next = redirect_pc;
        if (imem_ack) begin
          addr_next  = redirect_valid ? redirect_pc : redir_reg;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= RESET_PC;
      redir_reg <= '0;
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      redir_reg <= redir_next;
      count_reg <= count_next;
      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]  <= addr_reg;
      ins_mem[tail_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: a behavioural instruction memory returns a
// PC-derived word; expected head PCs are queued per scenario and compared
// as the DUT presents them.
module tb_ifetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [7:0]  inst_pc;
  logic [2:0]  count;

  logic        ack_en;
  logic [7:0]  exp_q[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  assign imem_ack   = ack_en;
  assign imem_rdata = mem_word(imem_addr);

  ifetch_queue #(.PC_W(8), .INS_W(32), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH at RESET_PC with an empty queue.
  task automatic do_reset();
    reset = 1'b1; ack_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ack_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;
    tick(); tick();
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 8'h00 || count !== 3'd0 ||
        inst_valid !== 1'b0 || inst !== NOP || inst_pc !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: req=%b addr=%h count=%0d valid=%b inst=%h pc=%h, want 0 00 0 0 %h 00",
               imem_req, imem_addr, count, inst_valid, inst, inst_pc, NOP);
    end
    reset = 1'b0;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL first_cycle_req: req=%b want 0", imem_req);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL first_req: req=%b addr=%h want 1 00", imem_req, imem_addr);
    end
    $display("reset: req=%b addr=%h", imem_req, imem_addr);
  endtask

  task automatic test_stream();
    int  cyc = 0;
    bit  started = 0;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    ack_en = 1'b1; inst_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < 40) begin
      if (inst_valid) begin
        started = 1;
        e = exp_q.pop_front();
        total++;
        if (inst_pc !== e || inst !== mem_word(e) || count > 3'd1) begin
          bad++;
          $display("FAIL stream_pop: pc=%h inst=%h count=%0d want pc=%h inst=%h count<=1",
                   inst_pc, inst, count, e, mem_word(e));
        end
        $display("stream pop pc=%h inst=%h", inst_pc, inst);
      end else if (started) begin
        total++; bad++;
        $display("FAIL stream_gap: valid=0 want 1 (next pc %h)", exp_q[0]);
      end
      tick(); cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL stream_timeout: left=%0d want 0", exp_q.size());
    end
    ack_en = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    ack_en = 1'b1;
    while (count != 3'd4 && cyc < 10) begin tick(); cyc++; end
    total++;
    if (count !== 3'd4 || imem_req !== 1'b0 || imem_addr !== 8'h04) begin
      bad++; $display("FAIL full: count=%0d req=%b addr=%h want 4 0 04", count, imem_req, imem_addr);
    end
    tick(); tick();
    total++;
    if (count !== 3'd4 || imem_req !== 1'b0) begin
      bad++; $display("FAIL full_hold: count=%0d req=%b want 4 0", count, imem_req);
    end
    e = exp_q.pop_front();
    total++;
    if (inst_pc !== e || inst !== mem_word(e)) begin
      bad++; $display("FAIL bp_pop: pc=%h inst=%h want %h %h", inst_pc, inst, e, mem_word(e));
    end
    $display("backpressure pop pc=%h inst=%h", inst_pc, inst);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; ack_en = 1'b0;
    total++;
    if (count !== 3'd3 || imem_req !== 1'b1 || imem_addr !== 8'h04) begin
      bad++; $display("FAIL refill_req: count=%0d req=%b addr=%h want 3 1 04", count, imem_req, imem_addr);
    end
    inst_ready = 1'b1; cyc = 0;
    while (exp_q.size() > 0 && cyc < 10) begin
      if (inst_valid) begin
        e = exp_q.pop_front();
        total++;
        if (inst_pc !== e || inst !== mem_word(e)) begin
          bad++; $display("FAIL bp_pop: pc=%h inst=%h want %h %h", inst_pc, inst, e, mem_word(e));
        end
        $display("backpressure pop pc=%h inst=%h", inst_pc, inst);
      end
      tick(); cyc++;
    end
    total++;
    if (exp_q.size() != 0 || count !== 3'd0) begin
      bad++; $display("FAIL bp_drain: left=%0d count=%0d want 0 0", exp_q.size(), count);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    logic [7:0] e;
    do_reset();
    ack_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h03;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    ack_en = 1'b0;
    total++;
    if (count !== 3'd2 || imem_addr !== 8'h05) begin
      bad++; $display("FAIL rw_setup: count=%0d addr=%h want 2 05", count, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++;
    if (count !== 3'd0 || inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== 8'h05) begin
      bad++; $display("FAIL rw_drain: count=%0d valid=%b inst=%h req=%b addr=%h want 0 0 %h 1 05",
                      count, inst_valid, inst, imem_req, imem_addr, NOP);
    end
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    total++;
    if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      bad++; $display("FAIL rw_restart: count=%0d req=%b addr=%h want 0 1 40", count, imem_req, imem_addr);
    end
    $display("redirect wait: restart addr=%h", imem_addr);
    redirect_valid = 1'b1; redirect_pc = 8'h55;
    tick();
    redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 8'h40 || imem_req !== 1'b1 || count !== 3'd0) begin
      bad++; $display("FAIL rw2_hold: addr=%h req=%b count=%0d want 40 1 0", imem_addr, imem_req, count);
    end
    ack_en = 1'b1;
    tick();
    total++;
    if (imem_addr !== 8'h80 || count !== 3'd0) begin
      bad++; $display("FAIL rw2_restart: addr=%h count=%0d want 80 0", imem_addr, count);
    end
    exp_q.push_back(8'h80);
    tick();
    ack_en = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== e || inst !== mem_word(e)) begin
      bad++; $display("FAIL rw2_first: valid=%b pc=%h inst=%h want 1 %h %h",
                      inst_valid, inst_pc, inst, e, mem_word(e));
    end
    $display("redirect latest pop pc=%h inst=%h", inst_pc, inst);
  endtask

  task automatic test_redirect_ack_pop();
    logic [7:0] e;
    do_reset();
    ack_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h05;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    total++;
    if (count !== 3'd2 || imem_addr !== 8'h07) begin
      bad++; $display("FAIL rap_setup: count=%0d addr=%h want 2 07", count, imem_addr);
    end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    total++;
    if (count !== 3'd0 || inst !== NOP || inst_pc !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      bad++; $display("FAIL rap_flush: count=%0d inst=%h pc=%h req=%b addr=%h want 0 %h 00 1 10",
                      count, inst, inst_pc, imem_req, imem_addr, NOP);
    end
    exp_q.push_back(8'h10);
    tick();
    ack_en = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst_pc !== e || inst !== mem_word(e) || count !== 3'd1) begin
      bad++; $display("FAIL rap_first: valid=%b pc=%h inst=%h count=%0d want 1 %h %h 1",
                      inst_valid, inst_pc, inst, count, e, mem_word(e));
    end
    $display("redirect+ack+pop pop pc=%h inst=%h", inst_pc, inst);
  endtask

  task automatic test_wrap();
    int  cyc = 0;
    bit  started = 0;
    logic [7:0] e;
    do_reset();
    ack_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    while (exp_q.size() > 0 && cyc < 20) begin
      if (inst_valid) begin
        started = 1;
        e = exp_q.pop_front();
        total++;
        if (inst_pc !== e || inst !== mem_word(e) || count > 3'd1) begin
          bad++; $display("FAIL wrap_pop: pc=%h inst=%h count=%0d want %h %h <=1",
                          inst_pc, inst, count, e, mem_word(e));
        end
        $display("wrap pop pc=%h inst=%h", inst_pc, inst);
      end else if (started) begin
        total++; bad++;
        $display("FAIL wrap_gap: valid=0 want 1 (next pc %h)", exp_q[0]);
      end
      tick(); cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL wrap_timeout: left=%0d want 0", exp_q.size());
    end
    ack_en = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_en = 1'b1;
    tick(); tick(); tick();
    ack_en = 1'b0;
    total++;
    if (count !== 3'd3 || imem_req !== 1'b1) begin
      bad++; $display("FAIL rm_setup: count=%0d req=%b want 3 1", count, imem_req);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; ack_en = 1'b1;
    total++;
    if (imem_req !== 1'b0 || count !== 3'd0 || inst_valid !== 1'b0 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL rm_reset: req=%b count=%0d valid=%b addr=%h want 0 0 0 00",
                      imem_req, count, inst_valid, imem_addr);
    end
    tick();
    total++;
    if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      bad++; $display("FAIL rm_late_ack: count=%0d req=%b addr=%h want 0 1 00", count, imem_req, imem_addr);
    end
    tick();
    ack_en = 1'b0;
    total++;
    if (count !== 3'd1 || inst_pc !== 8'h00 || inst !== mem_word(8'h00)) begin
      bad++; $display("FAIL rm_first: count=%0d pc=%h inst=%h want 1 00 %h",
                      count, inst_pc, inst, mem_word(8'h00));
    end
    $display("reset mid-op: first pc=%h inst=%h", inst_pc, inst);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath.
- Owns the word-addressed program counter and issues requests to a variable-latency instruction memory.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to the datapath over a valid/ready handshake; a redirect input (branch/jump target) flushes the queue and restarts fetch.

Parameters:
- PC_W, 8, PC / instruction-memory word-address width.
- INS_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  PC_W  fetch word address, registered; stable while imem_req=1.
- imem_ack  in  1  memory returns data this cycle; meaningful only while imem_req=1.
- imem_rdata  in  INS_W  instruction data, valid with imem_ack.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  PC_W  redirect target.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  datapath consumes the head.
- inst  out  INS_W  head instruction; 32'h00000013 (NOP) when empty.
- inst_pc  out  PC_W  head PC; 0 when empty.
- count  out  clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=IDLE, imem_req=0, imem_addr=RESET_PC, redir_pc=0.
  - Queue emptied: count=0, inst_valid=0, inst=NOP, inst_pc=0.
- Reset mid-request: the outstanding request is abandoned and any ack in the following cycles is ignored while state=IDLE.
- Handshake events:
  - push = imem_req & imem_ack & (state==FETCH) & !redirect_valid.
  - pop = inst_valid & inst_ready & !redirect_valid.
  - count_next = count + push - pop.
- Queue behaviour:
  - Simultaneous push and pop is legal at any occupancy.
  - Overflow is impossible because a request is issued only with space reserved.
- Outputs:
  - inst and inst_pc are driven combinationally from the head entry, or from the empty defaults.
  - inst_valid = (count != 0).
- FSM; imem_addr is the fetch PC register:
  - IDLE (req=0):
    - redirect: flush queue, imem_addr<=redirect_pc, go to FETCH.
    - Else if count_next < DEPTH: go to FETCH.
    - Else stay in IDLE.
  - FETCH (req=1):
    - No ack, no redirect: hold.
    - No ack, redirect: flush queue, redir_pc<=redirect_pc, go to DRAIN. imem_addr is held until the in-flight request completes.
    - Ack, no redirect: push {imem_addr, imem_rdata}, imem_addr<=imem_addr+1 (wraps modulo 2^PC_W). Stay in FETCH if count_next < DEPTH, else go to IDLE.
    - Ack with redirect: discard the data, flush, imem_addr<=redirect_pc, stay in FETCH.
  - DRAIN (req=1, addr held):
    - Returned data is always discarded.
    - A redirect while in DRAIN overwrites redir_pc; the latest redirect wins.
    - On ack: imem_addr<=(redirect_valid ? redirect_pc : redir_pc), go to FETCH.
- Redirect has priority over pop: a pop in the same cycle has no effect; the queue is empty the next cycle.
- Throughput: one instruction per cycle when imem_ack is tied high and inst_ready=1.
- Latency: a fetched instruction is visible on inst the cycle after its ack.
- First request: imem_req rises on the second cycle after reset deasserts (IDLE→FETCH).
- At most one request is outstanding at any time.

Test Plan:
- Zero-wait stream:
  - Stimulus: ack tied 1, inst_ready=1, RESET_PC=0, after reset.
  - Required: inst_pc sequence 0,1,2,3… on consecutive cycles; inst matches memory contents; count stays ≤1.
- Backpressure to full:
  - Stimulus: inst_ready=0, ack tied 1, DEPTH=4.
  - Required: count reaches 4; imem_req drops; no further pushes.
  - Then raise inst_ready for one cycle: count goes 3; req reasserts at addr 4; entries pop in order 0,1,2,3.
- Redirect during wait:
  - Stimulus: request at addr 5 un-acked; redirect to 0x40.
  - Required: queue empties; imem_addr stays 5 until ack; that ack's data is not pushed; next request is at 0x40.
  - Variant: a second redirect to 0x80 during DRAIN makes the next request 0x80.
- Redirect coincident with ack and pop:
  - Stimulus: count=2, ack for addr 7, inst_ready=1, redirect to 0x10, all in one cycle.
  - Required: next cycle count=0, inst=NOP, imem_req=1, imem_addr=0x10.
- Wrap-around:
  - Stimulus: PC_W=8, fetch from 0xFE with ack tied 1.
  - Required: inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation:
  - Stimulus: reset with count=3 and a request outstanding.
  - Required: next cycle imem_req=0, count=0, inst_valid=0, imem_addr=RESET_PC; a late ack is ignored.
